// File: rtl/load_use_stall_unit_pkg.sv
// Shared pipeline definitions: opcodes, writer-opcode test, scoreboard entry and
// interlock FSM state encoding.
package load_use_stall_unit_pkg;

    localparam logic [5:0] OP_ALU   = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LOAD  = 6'd34;

    typedef struct packed {
        logic       valid;
        logic       isLoad;
        logic [4:0] ds;
    } sbEntry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD1 = 2'd1,
        HOLD2 = 2'd2
    } stallState_t;

    // Same producer set the forwarding unit uses to decide who writes a register.
    function automatic logic isWriter(input logic [5:0] op);
        case (op)
            OP_ALU, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_XORI, OP_LOAD: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic sbEntry_t invalidEntry();
        return '{valid: 1'b0, isLoad: 1'b0, ds: 5'd0};
    endfunction

endpackage

// File: rtl/load_use_stall_unit_if.sv
// Issue-side bundle between the If stage and the load-use interlock.
interface load_use_stall_unit_if;

    logic        Enable;
    logic        IfValid;
    logic [5:0]  IfOp;
    logic [4:0]  IfRs;
    logic [4:0]  IfRt;
    logic [4:0]  IfDs;
    logic        Flush;
    logic        StallIf;
    logic        BubbleRr;
    logic        Busy;
    logic [15:0] StallCount;

    modport master (
        output Enable, IfValid, IfOp, IfRs, IfRt, IfDs, Flush,
        input  StallIf, BubbleRr, Busy, StallCount
    );

    modport slave (
        input  Enable, IfValid, IfOp, IfRs, IfRt, IfDs, Flush,
        output StallIf, BubbleRr, Busy, StallCount
    );

endinterface

// File: rtl/load_use_stall_unit_scoreboard.sv
// Three-entry destination scoreboard (Rr, Calcs, Dm) with load-match outputs
// for the If-stage source registers.
module stall_scoreboard
    import load_use_stall_unit_pkg::*;
(
    input  logic     Clk,
    input  logic     Rst_n,
    input  sbEntry_t ifEntry,
    input  logic     killRr,
    input  logic [4:0] ifRs,
    input  logic [4:0] ifRt,
    output logic     hitRr,
    output logic     hitCalcs,
    output logic     hitDm
);

    sbEntry_t rrEntry;
    sbEntry_t calcsEntry;
    sbEntry_t dmEntry;

    function automatic logic srcHit(input logic [4:0] src, input sbEntry_t e);
        return (src != 5'd0) && e.valid && e.isLoad && (src == e.ds);
    endfunction

    // NOTE: only three entries, so every one is reset; a stale valid bit
    // after reset would raise a phantom stall on the first instruction.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rrEntry    <= invalidEntry();
            calcsEntry <= invalidEntry();
            dmEntry    <= invalidEntry();
        end else begin
            // NOTE: non-blocking so all three stages shift from pre-edge values.
            dmEntry    <= calcsEntry;
            calcsEntry <= rrEntry;
            rrEntry    <= killRr ? invalidEntry() : ifEntry;
        end
    end

    assign hitRr    = srcHit(ifRs, rrEntry)    | srcHit(ifRt, rrEntry);
    assign hitCalcs = srcHit(ifRs, calcsEntry) | srcHit(ifRt, calcsEntry);
    assign hitDm    = srcHit(ifRs, dmEntry)    | srcHit(ifRt, dmEntry);

endmodule

// File: rtl/load_use_stall_unit.sv
// Load-use interlock: stalls If/Rr and bubbles Rr until Dm forwarding can
// supply a load result, and counts stall cycles (saturating).
module load_use_stall_unit
    import load_use_stall_unit_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Rst_n,
    load_use_stall_unit_if.slave  bus
);

    sbEntry_t    ifEntry;
    logic        hitRr;
    logic        hitCalcs;
    logic        dmHitUnused;
    logic        hazard;
    logic        stallIf;
    logic        bubbleRr;
    stallState_t state;
    stallState_t nextState;
    logic [15:0] stallCount;

    assign ifEntry.valid  = bus.IfValid & isWriter(bus.IfOp) & (bus.IfDs != 5'd0);
    assign ifEntry.isLoad = (bus.IfOp == OP_LOAD);
    assign ifEntry.ds     = bus.IfDs;

    // Dm matches are satisfied by forwarding; the hit is kept only for visibility.
    stall_scoreboard uScoreboard (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .ifEntry  (ifEntry),
        .killRr   (bubbleRr | bus.Flush),
        .ifRs     (bus.IfRs),
        .ifRt     (bus.IfRt),
        .hitRr    (hitRr),
        .hitCalcs (hitCalcs),
        .hitDm    (dmHitUnused)
    );

    assign hazard = bus.IfValid & (hitRr | hitCalcs);

    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        nextState = state;
        stallIf   = 1'b0;
        bubbleRr  = 1'b0;
        if (!bus.Enable || bus.Flush) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE, HOLD1: begin
                    if (hazard) begin
                        stallIf   = 1'b1;
                        bubbleRr  = 1'b1;
                        nextState = hitRr ? HOLD2 : HOLD1;
                    end else begin
                        nextState = IDLE;
                    end
                end
                HOLD2: begin
                    stallIf   = 1'b1;
                    bubbleRr  = 1'b1;
                    nextState = HOLD1;
                end
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            stallCount <= 16'd0;
        end else begin
            state <= nextState;
            if (stallIf && (stallCount != 16'hFFFF)) begin
                stallCount <= stallCount + 16'd1;
            end
        end
    end

    assign bus.StallIf    = stallIf;
    assign bus.BubbleRr   = bubbleRr;
    assign bus.Busy       = (state != IDLE);
    assign bus.StallCount = stallCount;

endmodule

// File: doc/load_use_stall_unit.md
# load_use_stall_unit

Pipeline interlock that complements the Dm-stage data forwarding path. It tracks the destination register of every in-flight instruction across the Rr, Calcs and Dm stages in a three-entry scoreboard. It stalls the If/Rr boundary and injects bubbles whenever a consumer needs a load result before Dm forwarding can supply it. It also keeps a saturating count of stall cycles for performance monitoring.

## Interface
- No parameters; opcode constants come from the shared pipeline package.
- Clk  input  1  pipeline clock, all state updates on rising edge
- Rst_n  input  1  asynchronous, active-low reset
- Enable  input  1  interlock enable; when 0 no stalls are raised and the scoreboard still shifts
- IfValid  input  1  instruction in If holds a real instruction
- IfOp  input  6  opcode of the If instruction
- IfRs, IfRt  input  5 each  source registers of the If instruction
- IfDs  input  5  destination register of the If instruction
- Flush  input  1  branch redirect; kills If and Rr contents
- StallIf  output  1  hold PC and the If/Rr register this cycle
- BubbleRr  output  1  load a NOP into Rr this cycle
- Busy  output  1  FSM is not IDLE
- StallCount  output  16  saturating count of stall cycles since reset

## Operation
- Writer opcodes are 0, 8, 9, 10, 12, 14 and 34, the same set as the forwarding producer set. Opcode 34 is the load.
- Each scoreboard entry holds {valid, isLoad, ds}, with one entry each for Rr, Calcs and Dm.
  - The If entry is formed as valid = IfValid & writer(IfOp) & (IfDs != 0).
  - ds = 0 is never tracked.
- Shift rules on each clock edge:
  - Calcs moves to Dm and Rr moves to Calcs unconditionally.
  - Rr loads the If entry when the unit is not stalling.
  - Rr loads an invalid entry when BubbleRr = 1 or Flush = 1.
- Hazard check is combinational on the If instruction. A source matches when it equals a tracked ds, the entry is valid with isLoad = 1, and the source is nonzero.
  - A match against the Rr entry is distance 1 and needs 2 stall cycles.
  - A match against the Calcs entry is distance 2 and needs 1 stall cycle.
  - A match against the Dm entry is covered by forwarding and needs no stall.
  - When both Rs and Rt match, the larger requirement wins.
- FSM states:
  - IDLE: on a hazard with Enable = 1 and Flush = 0, assert StallIf and BubbleRr in the same cycle. Go to HOLD2 if 2 cycles are needed, otherwise to HOLD1. With no hazard, remain in IDLE.
  - HOLD2: assert StallIf and BubbleRr, then go to HOLD1.
  - HOLD1: deassert both outputs, re-evaluate the hazard as in IDLE, and go to IDLE when it is clear.
- Flush in any state forces the next state to IDLE, clears the Rr entry, and deasserts StallIf that cycle.
- Enable = 0 forces IDLE and both outputs to 0. The scoreboard keeps shifting.
- StallCount increments by 1 on each cycle with StallIf = 1 and holds at 16'hFFFF.

## Timing
- The decision is combinational from the If inputs and the registered scoreboard, so StallIf and BubbleRr appear in the same cycle as the hazard. There is no added latency.
- A dependent instruction directly after a load sees exactly 2 stall cycles. With one independent instruction between them it sees 1 stall cycle.
- Reset values:
  - FSM state = IDLE.
  - All scoreboard entries are invalid.
  - StallIf = 0, BubbleRr = 0, Busy = 0, StallCount = 0.
- Reset asserted mid-stall clears everything immediately (asynchronous). Pipeline issue resumes on the first edge after Rst_n rises.
- When Flush and a hazard occur in the same cycle, Flush wins and no stall is raised.

## Structure
- The shared pipeline package holds:
  - Opcode constants, including OP_LOAD = 34.
  - The writer-opcode membership function, shared with the forwarding unit.
  - The scoreboard entry struct {valid, isLoad, ds[4:0]}.
  - The FSM state enum {IDLE, HOLD1, HOLD2}.
- One sub-module, stall_scoreboard, holds the three-entry shift register and its match outputs.
- The FSM and the counter live in the top module.

## Test plan
- Load r5 issues, then `add r7,r5,r6` in the next cycle -> StallIf = 1 and BubbleRr = 1 for exactly 2 cycles, the add enters Rr on the 3rd cycle, StallCount = 2.
- Load r5, then an independent instruction, then a consumer of r5 -> exactly 1 stall cycle.
- Load r0, then a consumer of r0 -> no stall. Load r5 followed by a consumer two instructions later (Dm distance) -> no stall.
- Hazard in HOLD2 with Flush = 1 -> next state IDLE, StallIf = 0 that cycle, Rr entry invalid.
- Enable = 0 during a load-use pair -> no stall, and the scoreboard still shifts: re-enabling 1 cycle later yields a 1-cycle stall.
- Force 70000 stall cycles -> StallCount saturates at 16'hFFFF. Pulse Rst_n low -> all outputs read 0 immediately.
